// File: rtl/udma_mram_pkg.sv
// rtl/udma_mram_pkg.sv - shared constants, command layout and FSM states for the uDMA MRAM responders
package udma_mram_pkg;

  localparam logic [2:0] MRAM_OP_READ = 3'b001;

  localparam logic [1:0] RX_ERR_OK     = 2'b00;
  localparam logic [1:0] RX_ERR_ZERO   = 2'b01;
  localparam logic [1:0] RX_ERR_RANGE  = 2'b10;
  localparam logic [1:0] RX_ERR_OPCODE = 2'b11;

  // Command word is {addr, size_bytes, flags}; flags sit in the low bits.
  localparam int CMD_FLAGS_W  = 11;
  localparam int CMD_OP_LSB   = 0;
  localparam int CMD_OP_W     = 3;
  localparam int CMD_ECC_BIT  = 3;
  localparam int CMD_RSVD_LSB = 4;
  localparam int CMD_SIZE_LSB = CMD_FLAGS_W;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_CHECK = 2'd1,
    RX_READ  = 2'd2,
    RX_DRAIN = 2'd3
  } rx_state_e;

endpackage

// File: rtl/udma_mram_rx_obuf.sv
// rtl/udma_mram_rx_obuf.sv - synchronous output FIFO holding MRAM read words until the RX data FIFO accepts them
module udma_mram_rx_obuf
  import udma_mram_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Callers reserve space before pushing, so push needs no full guard.
  assign pop_ok  = pop_i && (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/udma_mram_rx_responder.sv
// rtl/udma_mram_rx_responder.sv - MRAM-side RX responder: validates a read command, streams MRAM words into the RX data FIFO
module udma_mram_rx_responder
  import udma_mram_pkg::*;
#(
  parameter int MRAM_ADDR_WIDTH = 16,
  parameter int TRANS_SIZE      = 16,
  parameter int RX_CMD_WIDTH    = MRAM_ADDR_WIDTH + TRANS_SIZE + 11,
  parameter int RX_DATA_WIDTH   = 64,
  parameter int READ_LATENCY    = 2,
  parameter int OUT_DEPTH       = 4
) (
  input  logic                       mram_clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [RX_CMD_WIDTH-1:0]    cmd_i,
  output logic                       data_valid_o,
  input  logic                       data_ready_i,
  output logic [RX_DATA_WIDTH-1:0]   data_o,
  output logic                       mram_ceb_o,
  output logic [MRAM_ADDR_WIDTH-1:0] mram_addr_o,
  output logic                       mram_eccbyps_o,
  input  logic [RX_DATA_WIDTH-1:0]   mram_rdata_i,
  output logic                       rx_busy_o,
  output logic [1:0]                 rx_error_o,
  output logic                       rx_done_o
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int SW = ((MRAM_ADDR_WIDTH + 1 > TRANS_SIZE) ? MRAM_ADDR_WIDTH + 1 : TRANS_SIZE) + 1;
  localparam int ADDR_LSB = CMD_SIZE_LSB + TRANS_SIZE;

  rx_state_e                  state_q;
  logic [MRAM_ADDR_WIDTH-1:0] addr_q;
  logic [TRANS_SIZE-1:0]      size_q;
  logic [TRANS_SIZE-1:0]      remain_q;
  logic [CMD_OP_W-1:0]        op_q;
  logic [READ_LATENCY-1:0]    vld_q;
  logic [READ_LATENCY-1:0]    vld_d;
  logic                       ready_q;
  logic                       busy_q;
  logic [1:0]                 err_q;
  logic                       done_q;
  logic                       ecc_q;

  logic [CW-1:0]              buf_count;
  logic [7:0]                 inflight;
  logic                       issue;
  logic                       capture;
  logic                       pop;
  logic [TRANS_SIZE-1:0]      words;
  logic [SW-1:0]              end_sum;
  logic                       range_err;
  logic                       unused_rsvd;

  assign unused_rsvd = ^cmd_i[CMD_FLAGS_W-1:CMD_RSVD_LSB];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + 8'(vld_q[i]);
  end

  // A slot is reserved per outstanding read, so the buffer can never overflow.
  assign issue   = (state_q == RX_READ) && ((8'(buf_count) + inflight) < 8'(OUT_DEPTH));
  assign capture = vld_q[READ_LATENCY-1];
  assign pop     = data_valid_o && data_ready_i;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int i = 1; i < READ_LATENCY; i++) vld_d[i] = vld_q[i-1];
  end

  assign words     = TRANS_SIZE'(1) + ((size_q - TRANS_SIZE'(1)) >> 3);
  assign end_sum   = SW'(addr_q) + SW'(words);
  assign range_err = end_sum > (SW'(1) << MRAM_ADDR_WIDTH);

  always_ff @(posedge mram_clk_i) begin
    if (rst_i) begin
      state_q  <= RX_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      remain_q <= '0;
      op_q     <= '0;
      vld_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= RX_ERR_OK;
      done_q   <= 1'b0;
      ecc_q    <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      done_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && cmd_valid_i) begin
            addr_q  <= cmd_i[ADDR_LSB +: MRAM_ADDR_WIDTH];
            size_q  <= cmd_i[CMD_SIZE_LSB +: TRANS_SIZE];
            op_q    <= cmd_i[CMD_OP_LSB +: CMD_OP_W];
            ecc_q   <= cmd_i[CMD_ECC_BIT];
            err_q   <= RX_ERR_OK;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RX_CHECK;
          end
        end
        RX_CHECK: begin
          remain_q <= words;
          if (op_q != MRAM_OP_READ || size_q == '0 || range_err) begin
            if (op_q != MRAM_OP_READ) err_q <= RX_ERR_OPCODE;
            else if (size_q == '0)    err_q <= RX_ERR_ZERO;
            else                      err_q <= RX_ERR_RANGE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= RX_IDLE;
          end else begin
            state_q <= RX_READ;
          end
        end
        RX_READ: begin
          if (issue) begin
            addr_q   <= addr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            if (remain_q == TRANS_SIZE'(1)) state_q <= RX_DRAIN;
          end
        end
        RX_DRAIN: begin
          if (inflight == '0 && buf_count == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  udma_mram_rx_obuf #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (RX_DATA_WIDTH)
  ) u_obuf (
    .clk_i   (mram_clk_i),
    .rst_i   (rst_i),
    .push_i  (capture),
    .data_i  (mram_rdata_i),
    .pop_i   (pop),
    .data_o  (data_o),
    .count_o (buf_count)
  );

  assign data_valid_o   = (buf_count != '0);
  assign cmd_ready_o    = ready_q;
  assign mram_ceb_o     = ~issue;
  assign mram_addr_o    = addr_q;
  assign mram_eccbyps_o = ecc_q;
  assign rx_busy_o      = busy_q;
  assign rx_error_o     = err_q;
  assign rx_done_o      = done_q;

endmodule

// File: tb/tb_udma_mram_rx_responder.sv
// tb/tb_udma_mram_rx_responder.sv - self-checking bench for udma_mram_rx_responder with an MRAM macro model
module tb_udma_mram_rx_responder;

  localparam int AW   = 16;
  localparam int TS   = 16;
  localparam int CMDW = AW + TS + 11;
  localparam int DW   = 64;
  localparam int L    = 2;
  localparam int D    = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            cmd_valid_i = 1'b0;
  logic            cmd_ready_o;
  logic [CMDW-1:0] cmd_i = '0;
  logic            data_valid_o;
  logic            data_ready_i = 1'b1;
  logic [DW-1:0]   data_o;
  logic            mram_ceb_o;
  logic [AW-1:0]   mram_addr_o;
  logic            mram_eccbyps_o;
  logic [DW-1:0]   mram_rdata_i = '0;
  logic            rx_busy_o;
  logic [1:0]      rx_error_o;
  logic            rx_done_o;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] salt;
  logic [AW-1:0] pa [L];
  logic          pv [L];

  logic [AW-1:0] iss_a [$];
  int            iss_c [$];
  logic [DW-1:0] out_d [$];
  int            out_c [$];
  int            acc_cyc;
  int            n_done;
  int            n_valid;

  udma_mram_rx_responder #(
    .MRAM_ADDR_WIDTH (AW),
    .TRANS_SIZE      (TS),
    .RX_CMD_WIDTH    (CMDW),
    .RX_DATA_WIDTH   (DW),
    .READ_LATENCY    (L),
    .OUT_DEPTH       (D)
  ) dut (
    .mram_clk_i     (clk),
    .rst_i          (rst_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_i          (cmd_i),
    .data_valid_o   (data_valid_o),
    .data_ready_i   (data_ready_i),
    .data_o         (data_o),
    .mram_ceb_o     (mram_ceb_o),
    .mram_addr_o    (mram_addr_o),
    .mram_eccbyps_o (mram_eccbyps_o),
    .mram_rdata_i   (mram_rdata_i),
    .rx_busy_o      (rx_busy_o),
    .rx_error_o     (rx_error_o),
    .rx_done_o      (rx_done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, ~a, a ^ salt, 16'hC3A5 ^ salt};
  endfunction

  // MRAM macro: word for an access with ceb low in cycle t is presented during cycle t+L
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) begin
      pa[i] = pa[i-1];
      pv[i] = pv[i-1];
    end
    pa[0] = mram_addr_o;
    pv[0] = !mram_ceb_o;
    mram_rdata_i <= pv[L-1] ? mem_word(pa[L-1]) : {$urandom(), $urandom()};
  end

  always @(negedge clk) begin
    if (cmd_valid_i && cmd_ready_o) acc_cyc = cyc;
    if (!mram_ceb_o) begin
      iss_a.push_back(mram_addr_o);
      iss_c.push_back(cyc);
    end
    if (data_valid_o && data_ready_i) begin
      out_d.push_back(data_o);
      out_c.push_back(cyc);
    end
    if (data_valid_o) n_valid++;
    if (rx_done_o) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [TS-1:0] sz, input logic [2:0] op, input logic ecc);
    int w = 0;
    while (!cmd_ready_o && w < 50) begin
      tick();
      w++;
    end
    chk("cmd_ready_wait", cmd_ready_o, 1);
    cmd_i       = {a, sz, 7'($urandom()), ecc, op};
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    cmd_i       = CMDW'({$urandom(), $urandom()});
  endtask

  task automatic run_cmd(input logic [AW-1:0] a, input logic [TS-1:0] sz, input logic [2:0] op,
                         input logic ecc, input int stall, input bit rnd_ready, input bit timing);
    int   words;
    int   e;
    int   n_exp;
    int   busy_bad = 0;
    int   stall_iss = 0;
    bit   done = 0;
    words = (sz == 0) ? 0 : 1 + (int'(sz) - 1) / 8;
    if (op != 3'b001)                e = 3;
    else if (sz == 0)                e = 1;
    else if (int'(a) + words > 65536) e = 2;
    else                             e = 0;
    n_exp = (e == 0) ? words : 0;
    iss_a.delete(); iss_c.delete(); out_d.delete(); out_c.delete();
    n_done = 0;
    data_ready_i = (stall > 0) ? 1'b0 : 1'b1;
    send(a, sz, op, ecc);
    chk("busy_after_accept", rx_busy_o, 1);
    for (int k = 0; k < 3000; k++) begin
      if (k == stall && stall > 0) stall_iss = iss_a.size();
      if (k >= stall) data_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      if (rx_done_o) begin
        done = 1;
        break;
      end
      if (!rx_busy_o) busy_bad++;
    end
    chk("done_seen", done, 1);
    data_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("rx_error", rx_error_o, e);
    chk("done_count", n_done, 1);
    chk("eccbyps", mram_eccbyps_o, ecc);
    chk("busy_during_cmd", busy_bad, 0);
    chk("busy_after_done", rx_busy_o, 0);
    chk("issue_count", iss_a.size(), n_exp);
    for (int i = 0; i < iss_a.size() && i < n_exp; i++) chk("issue_addr", iss_a[i], 16'(a + 16'(i)));
    chk("out_count", out_d.size(), n_exp);
    for (int i = 0; i < out_d.size() && i < n_exp; i++) chk("out_data", out_d[i], mem_word(16'(a + 16'(i))));
    if (stall > 0) chk("stall_credit", stall_iss <= D, 1);
    if (timing && n_exp > 0 && iss_c.size() == n_exp && out_c.size() == n_exp) begin
      chk("lat_accept_to_issue", iss_c[0] - acc_cyc, 2);
      chk("lat_issue_to_valid", out_c[0] - iss_c[0], L + 1);
      chk("issue_back_to_back", iss_c[n_exp-1] - iss_c[0], n_exp - 1);
      chk("out_back_to_back", out_c[n_exp-1] - out_c[0], n_exp - 1);
    end
  endtask

  initial begin
    int w;
    salt = 16'($urandom());
    for (int i = 0; i < L; i++) begin
      pa[i] = '0;
      pv[i] = 1'b0;
    end

    rst_i = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_data_valid", data_valid_o, 0);
    chk("rst_ceb", mram_ceb_o, 1);
    chk("rst_addr", mram_addr_o, 0);
    chk("rst_ecc", mram_eccbyps_o, 0);
    chk("rst_busy", rx_busy_o, 0);
    chk("rst_error", rx_error_o, 0);
    chk("rst_done", rx_done_o, 0);
    rst_i = 1'b0;
    tick();
    chk("cmd_ready_after_rst", cmd_ready_o, 1);

    run_cmd(16'h0010, 16'd32, 3'b001, 1'b0, 0, 0, 1);
    run_cmd(16'h0200, 16'd20, 3'b001, 1'b1, 0, 0, 1);
    run_cmd(16'h0400, 16'd64, 3'b001, 1'b0, 20, 0, 0);
    run_cmd(16'hFFFE, 16'd24, 3'b001, 1'b0, 0, 0, 0);
    run_cmd(16'h0300, 16'd0, 3'b001, 1'b0, 0, 0, 0);
    run_cmd(16'h0300, 16'd16, 3'b010, 1'b1, 0, 0, 0);
    run_cmd(16'hFFFC, 16'd32, 3'b001, 1'b0, 0, 0, 1);

    iss_a.delete(); iss_c.delete();
    send(16'h0100, 16'd64, 3'b001, 1'b0);
    w = 0;
    while (iss_a.size() < 2 && w < 20) begin
      tick();
      w++;
    end
    chk("reset_test_issues", iss_a.size() >= 2, 1);
    rst_i = 1'b1;
    tick();
    chk("midrst_cmd_ready", cmd_ready_o, 0);
    chk("midrst_data_valid", data_valid_o, 0);
    chk("midrst_ceb", mram_ceb_o, 1);
    chk("midrst_addr", mram_addr_o, 0);
    chk("midrst_ecc", mram_eccbyps_o, 0);
    chk("midrst_busy", rx_busy_o, 0);
    chk("midrst_error", rx_error_o, 0);
    chk("midrst_done", rx_done_o, 0);
    rst_i = 1'b0;
    n_valid = 0;
    iss_a.delete(); iss_c.delete();
    for (int k = 0; k < 10; k++) tick();
    chk("no_late_valid", n_valid, 0);
    chk("no_issue_after_rst", iss_a.size(), 0);
    run_cmd(16'h0040, 16'd40, 3'b001, 1'b0, 0, 0, 1);

    for (int r = 0; r < 12; r++) begin
      logic [AW-1:0] ra;
      logic [TS-1:0] rs;
      logic [2:0]    ro;
      ra = ($urandom_range(0, 2) == 0) ? 16'(16'hFFE0 + $urandom_range(0, 31)) : 16'($urandom());
      rs = 16'($urandom_range(0, 120));
      ro = ($urandom_range(0, 4) == 0) ? 3'($urandom()) : 3'b001;
      run_cmd(ra, rs, ro, 1'($urandom()), $urandom_range(0, 1) * 8, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
